// File: rtl/ins_decode_buffer_pkg.sv
// Shared decode constants: immediate-format codes and RISC-V major opcodes.
// Imported by the decode buffer and the opcode classifier.
package ins_decode_buffer_pkg;

    typedef enum logic [2:0] {
        ITYPE = 3'd0,
        STYPE = 3'd1,
        BTYPE = 3'd2,
        UTYPE = 3'd3,
        JTYPE = 3'd4,
        NTYPE = 3'd5,
        RTYPE = 3'd6
    } ins_type_e;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_AMO       = 7'b0101111;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/ins_decode_buffer_classify.sv
// ins_type_classify: maps an instruction opcode to its immediate-format code.
// Purely combinational so any decode stage can reuse it.
module ins_type_classify
    import ins_decode_buffer_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] type_o,
    output logic       illegal_o
);

    ins_type_e type_d;
    logic      illegal_d;

    always_comb begin
        type_d    = NTYPE;
        illegal_d = 1'b1;
        // Compressed encodings (low bits != 11) are rejected outright.
        if (opcode_i[1:0] == 2'b11) begin
            case (opcode_i)
                OP_LOAD, OP_OP_IMM, OP_OP_IMM_32, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
                    type_d    = ITYPE;
                    illegal_d = 1'b0;
                end
                OP_STORE: begin
                    type_d    = STYPE;
                    illegal_d = 1'b0;
                end
                OP_BRANCH: begin
                    type_d    = BTYPE;
                    illegal_d = 1'b0;
                end
                OP_LUI, OP_AUIPC: begin
                    type_d    = UTYPE;
                    illegal_d = 1'b0;
                end
                OP_JAL: begin
                    type_d    = JTYPE;
                    illegal_d = 1'b0;
                end
                OP_OP, OP_OP_32, OP_AMO: begin
                    type_d    = RTYPE;
                    illegal_d = 1'b0;
                end
                default: begin
                    type_d    = NTYPE;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    assign type_o    = type_d;
    assign illegal_o = illegal_d;

endmodule

// File: rtl/ins_decode_buffer.sv
// Decode front end: small FIFO of {PC, instruction, format, illegal} entries.
// Classification happens on write so the head entry drives outputs directly.
module ins_decode_buffer
    import ins_decode_buffer_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [PC_WIDTH-1:0] IN_PC,
    input  logic [31:0]         IN_INS,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [PC_WIDTH-1:0] OUT_PC,
    output logic [31:0]         OUT_INS,
    output logic [2:0]          OUT_TYPE,
    output logic [4:0]          OUT_RD,
    output logic [4:0]          OUT_RS1,
    output logic [4:0]          OUT_RS2,
    output logic                OUT_ILLEGAL
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0] pc_q   [DEPTH];
    logic [31:0]         ins_q  [DEPTH];
    logic [2:0]          type_q [DEPTH];
    logic                ill_q  [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       push, pop;
    logic [2:0] in_type;
    logic       in_illegal;

    ins_type_classify u_classify (
        .opcode_i  (IN_INS[6:0]),
        .type_o    (in_type),
        .illegal_o (in_illegal)
    );

    assign IN_READY  = (count_q != CNT_W'(DEPTH));
    assign OUT_VALID = (count_q != '0);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (FLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the idle outputs show zeros and ntype.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                ins_q[i]  <= '0;
                type_q[i] <= NTYPE;
                ill_q[i]  <= 1'b0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push && !FLUSH) begin
                pc_q[wptr_q]   <= IN_PC;
                ins_q[wptr_q]  <= IN_INS;
                type_q[wptr_q] <= in_type;
                ill_q[wptr_q]  <= in_illegal;
            end
        end
    end

    assign OUT_PC      = pc_q[rptr_q];
    assign OUT_INS     = ins_q[rptr_q];
    assign OUT_TYPE    = type_q[rptr_q];
    assign OUT_ILLEGAL = ill_q[rptr_q];
    assign OUT_RD      = ins_q[rptr_q][11:7];
    assign OUT_RS1     = ins_q[rptr_q][19:15];
    assign OUT_RS2     = ins_q[rptr_q][24:20];

endmodule

// File: tb/tb_ins_decode_buffer.sv
// Testbench for ins_decode_buffer: directed scenarios then random traffic,
// checked against a queue-based reference of the buffer contents.
module tb_ins_decode_buffer;

    localparam int DEPTH    = 2;
    localparam int PC_WIDTH = 64;

    logic                CLK = 1'b0;
    logic                RST, FLUSH, IN_VALID, OUT_READY;
    logic                IN_READY, OUT_VALID, OUT_ILLEGAL;
    logic [PC_WIDTH-1:0] IN_PC, OUT_PC;
    logic [31:0]         IN_INS, OUT_INS;
    logic [2:0]          OUT_TYPE;
    logic [4:0]          OUT_RD, OUT_RS1, OUT_RS2;

    ins_decode_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .FLUSH       (FLUSH),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_PC       (IN_PC),
        .IN_INS      (IN_INS),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_PC      (OUT_PC),
        .OUT_INS     (OUT_INS),
        .OUT_TYPE    (OUT_TYPE),
        .OUT_RD      (OUT_RD),
        .OUT_RS1     (OUT_RS1),
        .OUT_RS2     (OUT_RS2),
        .OUT_ILLEGAL (OUT_ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         ins;
    } entry_t;

    entry_t mq[$];
    bit     reset_clean;
    int     n_vec = 0;
    int     n_mis = 0;

    // Returns {illegal, type} from the opcode table.
    function automatic logic [3:0] ref_class(input logic [31:0] ins);
        if (ins[1:0] != 2'b11) return {1'b1, 3'd5};
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b0001111, 7'b1110011: return {1'b0, 3'd0};
            7'b0100011:                         return {1'b0, 3'd1};
            7'b1100011:                         return {1'b0, 3'd2};
            7'b0110111, 7'b0010111:             return {1'b0, 3'd3};
            7'b1101111:                         return {1'b0, 3'd4};
            7'b0110011, 7'b0111011, 7'b0101111: return {1'b0, 3'd6};
            default:                            return {1'b1, 3'd5};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] cls;
        chk("out_valid", 64'(OUT_VALID), 64'(mq.size() != 0));
        chk("in_ready", 64'(IN_READY), 64'(mq.size() != DEPTH));
        if (mq.size() != 0) begin
            cls = ref_class(mq[0].ins);
            chk("out_pc", OUT_PC, mq[0].pc);
            chk("out_ins", 64'(OUT_INS), 64'(mq[0].ins));
            chk("out_type", 64'(OUT_TYPE), 64'(cls[2:0]));
            chk("out_illegal", 64'(OUT_ILLEGAL), 64'(cls[3]));
            chk("out_rd", 64'(OUT_RD), 64'(mq[0].ins[11:7]));
            chk("out_rs1", 64'(OUT_RS1), 64'(mq[0].ins[19:15]));
            chk("out_rs2", 64'(OUT_RS2), 64'(mq[0].ins[24:20]));
        end else if (reset_clean) begin
            chk("rst_pc", OUT_PC, 64'd0);
            chk("rst_ins", 64'(OUT_INS), 64'd0);
            chk("rst_type", 64'(OUT_TYPE), 64'd5);
            chk("rst_illegal", 64'(OUT_ILLEGAL), 64'd0);
            chk("rst_regs", 64'({OUT_RD, OUT_RS1, OUT_RS2}), 64'd0);
        end
    endtask

    // Drive one cycle, advance the reference at the edge, then check.
    task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl, input logic rs);
        bit do_push, do_pop;
        IN_VALID  = v;
        IN_PC     = pc;
        IN_INS    = ins;
        OUT_READY = rdy;
        FLUSH     = fl;
        RST       = rs;
        do_push = v && (mq.size() != DEPTH);
        do_pop  = rdy && (mq.size() != 0);
        @(posedge CLK);
        #1;
        if (rs) begin
            mq.delete();
            reset_clean = 1'b1;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: pc, ins: ins});
                reset_clean = 1'b0;
            end
        end
        check_all();
    endtask

    initial begin
        logic [6:0]  ops [16];
        logic [31:0] r, w;
        ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0001111, 7'b1110011,
                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                7'b0111011, 7'b0101111, 7'b1111111, 7'b0000000};
        reset_clean = 1'b1;
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        IN_PC = '0; IN_INS = '0;

        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0);

        // addi x1,x0,5
        cycle(1, 64'h1000, 32'h00500093, 1, 0, 0);
        chk("addi_type", 64'(OUT_TYPE), 64'd0);
        chk("addi_rd", 64'(OUT_RD), 64'd1);
        cycle(0, 0, 0, 1, 0, 0);

        // Fill while stalled, then drain in order
        cycle(1, 64'h2000, 32'h00112023, 0, 0, 0);
        cycle(1, 64'h2004, 32'hFE000EE3, 0, 0, 0);
        chk("full_in_ready", 64'(IN_READY), 64'd0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("stall_type", 64'(OUT_TYPE), 64'd1);
        cycle(0, 0, 0, 1, 0, 0);
        chk("drain_type", 64'(OUT_TYPE), 64'd2);
        chk("drain_pc", OUT_PC, 64'h2004);
        cycle(0, 0, 0, 1, 0, 0);

        // Back-to-back stream, one entry per cycle
        cycle(1, 64'h3000, 32'h000012B7, 1, 0, 0);
        chk("stream_lui", 64'(OUT_TYPE), 64'd3);
        cycle(1, 64'h3004, 32'h0000006F, 1, 0, 0);
        chk("stream_jal", 64'(OUT_TYPE), 64'd4);
        cycle(1, 64'h3008, 32'h002081B3, 1, 0, 0);
        chk("stream_add", 64'(OUT_TYPE), 64'd6);
        cycle(0, 0, 0, 1, 0, 0);

        // Full plus pop: push refused, count drops to 1
        cycle(1, 64'h4000, 32'h00500093, 0, 0, 0);
        cycle(1, 64'h4004, 32'h00112023, 0, 0, 0);
        cycle(1, 64'h4008, 32'h0000006F, 1, 0, 0);
        chk("fullpop_pc", OUT_PC, 64'h4004);
        cycle(0, 0, 0, 1, 0, 0);
        chk("fullpop_empty", 64'(OUT_VALID), 64'd0);

        // Flush with a concurrent push
        cycle(1, 64'h5000, 32'h00500093, 0, 0, 0);
        cycle(1, 64'h5004, 32'h00112023, 0, 0, 0);
        cycle(1, 64'h5008, 32'h0000006F, 1, 1, 0);
        chk("flush_valid", 64'(OUT_VALID), 64'd0);
        cycle(0, 0, 0, 1, 0, 0);

        // Illegal encodings
        cycle(1, 64'h6000, 32'h00000000, 1, 0, 0);
        chk("ill0_type", 64'(OUT_TYPE), 64'd5);
        chk("ill0_flag", 64'(OUT_ILLEGAL), 64'd1);
        cycle(1, 64'h6004, 32'h0000007F, 1, 0, 0);
        chk("ill7f_flag", 64'(OUT_ILLEGAL), 64'd1);
        cycle(1, 64'h6008, 32'h00500093, 0, 0, 0);

        // Reset wins over flush and handshakes
        cycle(1, 64'h7000, 32'h00112023, 1, 1, 1);
        chk("rst_type_final", 64'(OUT_TYPE), 64'd5);
        cycle(0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if ($urandom_range(3) == 0) w = $urandom();
            else w = {r[31:7], ops[$urandom_range(15)]};
            cycle(logic'($urandom_range(3) != 0), {$urandom(), $urandom()}, w,
                  logic'($urandom_range(2) != 0), logic'($urandom_range(24) == 0),
                  logic'($urandom_range(79) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
